line_raster_ctrl: RTL and testbench
===================================

LINE_RASTER_CTRL -- requirements
Module: line_raster_ctrl

Interface
REQ-001 SHALL have parameter COORD_W, default 8, meaning width of each unsigned point coordinate.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port cmd_valid  input  1  line command present.
REQ-005 SHALL have port cmd_ready  output  1  controller can accept a command.
REQ-006 SHALL have ports x0, y0, x1, y1  input  COORD_W each  line start and end coordinates, sampled on command handshake.
REQ-007 SHALL have port abort  input  1  synchronous cancel of the line in progress.
REQ-008 SHALL have port pt_valid  output  1  pt_x/pt_y hold a valid point.
REQ-009 SHALL have port pt_ready  input  1  downstream consumer accepts the point.
REQ-010 SHALL have ports pt_x, pt_y  output  COORD_W each  current point coordinates.
REQ-011 SHALL have port pt_last  output  1  current point equals (x1,y1).
REQ-012 SHALL have port busy  output  1  state is not IDLE.
REQ-013 SHALL have port pt_count  output  COORD_W+1  points handshaken for the current or most recent line.

Function
REQ-014 SHALL implement states IDLE, SETUP, DRAW. A command handshake (cmd_valid and cmd_ready) moves IDLE->SETUP. SETUP always moves to DRAW after one cycle. DRAW moves to IDLE on the handshake of the pt_last point, or on abort.
REQ-015 SHALL drive cmd_ready high only in IDLE, as a function of state alone.
REQ-016 SHALL, on the command handshake, register x0/y0/x1/y1 and clear pt_count to 0.
REQ-017 SHALL, in SETUP, compute the following: dx=|x1-x0|; dy=-|y1-y0|; sx=+1 if x0<x1, else -1; sy=+1 if y0<y1, else -1; err=dx+dy. err SHALL be signed, width COORD_W+2, with no overflow for any input.
REQ-018 SHALL assert pt_valid throughout DRAW, so the first point is valid two cycles after the command handshake cycle.
REQ-019 SHALL, on each point handshake in DRAW that is not the last, advance using Bresenham stepping with e2=2*err:
- if e2>=dy: err+=dy and x+=sx;
- if e2<=dx: err+=dx and y+=sy;
- both updates use the pre-step err, and both may apply in the same cycle.
REQ-020 SHALL emit exactly max(dx,|dy|)+1 points per line, ordered from (x0,y0) to (x1,y1), with no duplicate points.
REQ-021 SHALL hold pt_x, pt_y and pt_last stable while pt_valid=1 and pt_ready=0.
REQ-022 SHALL increment pt_count by 1 on each point handshake, and hold it in IDLE until the next command.
REQ-023 SHALL emit one point with pt_last=1 for a degenerate line (x0==x1 and y0==y1).
REQ-024 SHALL, when abort=1 in SETUP or DRAW, enter IDLE next cycle with pt_valid=0. A point handshake in the abort cycle SHALL still count, and abort SHALL take priority over pt_last completion. abort SHALL be ignored in IDLE.
REQ-025 SHALL raise cmd_ready in the cycle after the final handshake; back-to-back commands SHALL lose no more than that cycle plus SETUP.
REQ-026 SHALL NOT produce X on any output once reset has been released, for any input sequence.

Reset
REQ-027 SHALL, while rst_n=0, hold the state in IDLE with the following outputs: cmd_ready=1, pt_valid=0, pt_last=0, busy=0, pt_x=0, pt_y=0, pt_count=0, internal err/dx/dy cleared.
REQ-028 SHALL, on reset asserted mid-line, abandon the line immediately (asynchronously). After release it SHALL emit no further points of that line and SHALL await a new command.

Verification
REQ-029 SHALL cover a diagonal-ish line: (3,4)->(6,8) with pt_ready=1 -> points (3,4),(4,5),(5,6),(5,7),(6,8); pt_last on (6,8) only; pt_count=5.
REQ-030 SHALL cover a reversed horizontal line: (5,2)->(2,2) -> points (5,2),(4,2),(3,2),(2,2); pt_count=4.
REQ-031 SHALL cover a degenerate line: (7,7)->(7,7) -> single point (7,7) with pt_last=1; cmd_ready high the next cycle.
REQ-032 SHALL cover backpressure: (0,0)->(3,1) with pt_ready low for 3 cycles on the 2nd point -> (1,0) held stable for those 3 cycles; sequence (0,0),(1,0),(2,1),(3,1).
REQ-033 SHALL cover abort: (0,0)->(9,0), abort asserted on the 3rd point handshake -> pt_count=3, pt_valid=0 next cycle, and the next command starts cleanly.
REQ-034 SHALL cover reset: rst_n pulsed low during DRAW of (0,0)->(255,255) -> all outputs take their reset values asynchronously, and no stale point appears after release.

Source files
------------

// File: rtl/line_raster_ctrl.sv
// Bresenham line rasterizer: accepts one (x0,y0)->(x1,y1) command and streams
// every integer point of the line over a valid/ready interface.
module line_raster_ctrl #(
    parameter int COORD_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    input  logic               abort,
    output logic               pt_valid,
    input  logic               pt_ready,
    output logic [COORD_W-1:0] pt_x,
    output logic [COORD_W-1:0] pt_y,
    output logic               pt_last,
    output logic               busy,
    output logic [COORD_W:0]   pt_count
);

    // Two extra bits: one for the sign, one so that 2*err never overflows.
    localparam int EW = COORD_W + 2;

    typedef enum logic [1:0] {IDLE, SETUP, DRAW} state_t;

    state_t                r_state, w_next;
    logic [COORD_W-1:0]    r_x, r_y, r_x1, r_y1;
    logic signed [EW-1:0]  r_dx, r_dy, r_err;
    logic                  r_sx_neg, r_sy_neg;
    logic [COORD_W:0]      r_count;

    logic                  w_cmd_hs, w_pt_hs, w_at_end;
    logic                  w_step_x, w_step_y;
    logic signed [EW-1:0]  w_e2, w_adx, w_ady, w_err_nx;

    assign w_cmd_hs = cmd_valid & cmd_ready;
    assign w_pt_hs  = pt_valid & pt_ready;
    assign w_at_end = (r_x == r_x1) && (r_y == r_y1);

    assign w_adx = (r_x1 > r_x) ? EW'(r_x1 - r_x) : EW'(r_x - r_x1);
    assign w_ady = (r_y1 > r_y) ? EW'(r_y1 - r_y) : EW'(r_y - r_y1);

    assign w_e2     = r_err <<< 1;
    assign w_step_x = (w_e2 >= r_dy);
    assign w_step_y = (w_e2 <= r_dx);
    assign w_err_nx = r_err + (w_step_x ? r_dy : '0) + (w_step_y ? r_dx : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        pt_valid  = 1'b0;
        busy      = 1'b1;
        case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) w_next = SETUP;
            end
            SETUP: w_next = abort ? IDLE : DRAW;
            DRAW: begin
                pt_valid = 1'b1;
                if (abort || (w_pt_hs && w_at_end)) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x      <= '0;
            r_y      <= '0;
            r_x1     <= '0;
            r_y1     <= '0;
            r_dx     <= '0;
            r_dy     <= '0;
            r_err    <= '0;
            r_sx_neg <= 1'b0;
            r_sy_neg <= 1'b0;
            r_count  <= '0;
        end else begin
            if (w_cmd_hs) begin
                r_x     <= x0;
                r_y     <= y0;
                r_x1    <= x1;
                r_y1    <= y1;
                r_count <= '0;
            end
            if (r_state == SETUP) begin
                r_dx     <= w_adx;
                r_dy     <= -w_ady;
                r_err    <= w_adx - w_ady;
                r_sx_neg <= !(r_x < r_x1);
                r_sy_neg <= !(r_y < r_y1);
            end
            // A handshake in the abort cycle still counts; only the stepping stops.
            if (r_state == DRAW && w_pt_hs) begin
                r_count <= r_count + (COORD_W+1)'(1);
                if (!w_at_end && !abort) begin
                    r_err <= w_err_nx;
                    if (w_step_x) r_x <= r_sx_neg ? r_x - COORD_W'(1) : r_x + COORD_W'(1);
                    if (w_step_y) r_y <= r_sy_neg ? r_y - COORD_W'(1) : r_y + COORD_W'(1);
                end
            end
        end
    end

    assign pt_x     = r_x;
    assign pt_y     = r_y;
    assign pt_last  = (r_state == DRAW) && w_at_end;
    assign pt_count = r_count;

endmodule

// File: tb/tb_line_raster_ctrl.sv
// Directed bench for line_raster_ctrl: table of lines with hand-derived point
// lists, plus sequences for backpressure, abort, mid-line reset and a 256-point line.
module tb_line_raster_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
    logic       abort = 1'b0;
    logic       pt_valid;
    logic       pt_ready = 1'b1;
    logic [7:0] pt_x, pt_y;
    logic       pt_last;
    logic       busy;
    logic [8:0] pt_count;

    int tests = 0;
    int fails = 0;

    line_raster_ctrl #(.COORD_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1),
        .abort(abort),
        .pt_valid(pt_valid), .pt_ready(pt_ready),
        .pt_x(pt_x), .pt_y(pt_y), .pt_last(pt_last),
        .busy(busy), .pt_count(pt_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x0, y0, x1, y1;
        int n;
        int px [8];
        int py [8];
    } vec_t;

    vec_t tbl [4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    // Returns at the negedge where the controller sits in SETUP.
    task automatic send_cmd(input int a, input int b, input int c, input int d);
        @(negedge clk);
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        x0 = 8'(a); y0 = 8'(b); x1 = 8'(c); y1 = 8'(d);
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("setup_state", 32'({pt_valid, busy, cmd_ready}), 32'b010);
    endtask

    task automatic run_vec(input int i);
        int k = 0;
        int cyc = 0;
        send_cmd(tbl[i].x0, tbl[i].y0, tbl[i].x1, tbl[i].y1);
        @(negedge clk);
        chk($sformatf("v%0d_first_lat", i), 32'(pt_valid), 32'd1);
        while (k < tbl[i].n && cyc < 600) begin
            if (pt_valid) begin
                chk($sformatf("v%0d_pt%0d", i, k), 32'({pt_x, pt_y, pt_last}),
                    32'({8'(tbl[i].px[k]), 8'(tbl[i].py[k]), (k == tbl[i].n - 1)}));
                k++;
            end
            cyc++;
            if (k < tbl[i].n) @(negedge clk);
        end
        if (k < tbl[i].n) chk($sformatf("v%0d_timeout", i), 32'(k), 32'(tbl[i].n));
        @(negedge clk);
        chk($sformatf("v%0d_done", i), 32'({pt_valid, busy, cmd_ready, pt_count}),
            32'({1'b0, 1'b0, 1'b1, 9'(tbl[i].n)}));
    endtask

    initial begin
        tbl[0] = '{3, 4, 6, 8, 5, '{3, 4, 5, 5, 6, 0, 0, 0}, '{4, 5, 6, 7, 8, 0, 0, 0}};
        tbl[1] = '{5, 2, 2, 2, 4, '{5, 4, 3, 2, 0, 0, 0, 0}, '{2, 2, 2, 2, 0, 0, 0, 0}};
        tbl[2] = '{7, 7, 7, 7, 1, '{7, 0, 0, 0, 0, 0, 0, 0}, '{7, 0, 0, 0, 0, 0, 0, 0}};
        tbl[3] = '{2, 0, 0, 5, 6, '{2, 2, 1, 1, 0, 0, 0, 0}, '{0, 1, 2, 3, 4, 5, 0, 0}};

        // Reset values while held in reset
        #12;
        chk("reset_vals", 32'({cmd_ready, pt_valid, pt_last, busy, pt_x, pt_y, pt_count}),
            32'({1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 9'd0}));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) run_vec(i);

        // Backpressure: (1,0) must hold for three stalled cycles
        send_cmd(0, 0, 3, 1);
        @(negedge clk);
        chk("bp_p0", 32'({pt_x, pt_y, pt_valid}), 32'({8'd0, 8'd0, 1'b1}));
        @(negedge clk);
        chk("bp_p1", 32'({pt_x, pt_y, pt_valid}), 32'({8'd1, 8'd0, 1'b1}));
        pt_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("bp_hold", 32'({pt_x, pt_y, pt_valid, pt_last}), 32'({8'd1, 8'd0, 1'b1, 1'b0}));
        end
        pt_ready = 1'b1;
        @(negedge clk);
        chk("bp_p2", 32'({pt_x, pt_y, pt_last}), 32'({8'd2, 8'd1, 1'b0}));
        @(negedge clk);
        chk("bp_p3", 32'({pt_x, pt_y, pt_last}), 32'({8'd3, 8'd1, 1'b1}));
        @(negedge clk);
        chk("bp_done", 32'({pt_valid, cmd_ready, pt_count}), 32'({1'b0, 1'b1, 9'd4}));

        // Abort on the third point handshake
        send_cmd(0, 0, 9, 0);
        @(negedge clk);
        chk("ab_p0", 32'({pt_x, pt_y, pt_valid}), 32'({8'd0, 8'd0, 1'b1}));
        @(negedge clk);
        chk("ab_p1", 32'({pt_x, pt_y, pt_valid}), 32'({8'd1, 8'd0, 1'b1}));
        @(negedge clk);
        chk("ab_p2", 32'({pt_x, pt_y, pt_valid}), 32'({8'd2, 8'd0, 1'b1}));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ab_done", 32'({pt_valid, busy, cmd_ready, pt_count}), 32'({1'b0, 1'b0, 1'b1, 9'd3}));
        run_vec(1);

        // Abort during SETUP, then abort while idle has no effect
        send_cmd(1, 1, 4, 4);
        abort = 1'b1;
        @(negedge clk);
        chk("ab_setup", 32'({pt_valid, busy, cmd_ready, pt_count}), 32'({1'b0, 1'b0, 1'b1, 9'd0}));
        @(negedge clk);
        chk("ab_idle", 32'({pt_valid, busy, cmd_ready}), 32'b001);
        abort = 1'b0;
        run_vec(2);

        // Asynchronous reset mid-line
        send_cmd(0, 0, 255, 255);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async", 32'({cmd_ready, pt_valid, pt_last, busy, pt_x, pt_y, pt_count}),
            32'({1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 9'd0}));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("rst_no_stale", 32'({pt_valid, busy}), 32'b00);
        end
        run_vec(0);

        // Full-range anti-diagonal: 256 points, every point on x+y=255
        begin
            int k = 0;
            int cyc = 0;
            bit ok = 1'b1;
            send_cmd(255, 0, 0, 255);
            @(negedge clk);
            while (k < 256 && cyc < 1000) begin
                if (pt_valid) begin
                    if ((int'(pt_x) + int'(pt_y) != 255) || (int'(pt_y) != k) ||
                        (pt_last != (k == 255)))
                        ok = 1'b0;
                    k++;
                end
                cyc++;
                if (k < 256) @(negedge clk);
            end
            chk("long_points", 32'({ok, 16'(k)}), 32'({1'b1, 16'd256}));
            @(negedge clk);
            chk("long_done", 32'({pt_valid, cmd_ready, pt_count}), 32'({1'b0, 1'b1, 9'd256}));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
